// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data, optional parity and stop bits
// of one frame, paced by an external baud tick, and drives the serializer and
// TX output mux controls.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter logic [1:0]  START_BIT_SELECT = 2'b00,
  parameter logic [1:0]  STOP_BIT_SELECT  = 2'b01,
  parameter logic [1:0]  SER_DATA_SELECT  = 2'b10,
  parameter logic [1:0]  PAR_BIT_SELECT   = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       data_valid,
  input  logic       par_en,
  output logic [1:0] bit_sel,
  output logic       ser_load,
  output logic       ser_shift,
  output logic       par_calc,
  output logic       busy,
  output logic       tx_done
);

  // Keep the counter at least one bit wide so DATA_WIDTH=1 still elaborates.
  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic            par_en_q;
  logic            tx_done_q;

  // Frame sequencing: state, bit counter, captured parity enable and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A tick arriving with the request is ignored; START waits for the next one.
          if (data_valid) begin
            state_q  <= StStart;
            par_en_q <= par_en;
          end
        end
        StStart: begin
          if (baud_tick) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (baud_tick) begin
            if (bit_cnt_q != LastBit) begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end else begin
              state_q <= par_en_q ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (baud_tick) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          if (baud_tick) begin
            state_q   <= StIdle;
            tx_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output mux select decoded from the current state.
  always_comb begin
    bit_sel = STOP_BIT_SELECT;
    unique case (state_q)
      StIdle:   bit_sel = STOP_BIT_SELECT;
      StStart:  bit_sel = START_BIT_SELECT;
      StData:   bit_sel = SER_DATA_SELECT;
      StParity: bit_sel = PAR_BIT_SELECT;
      StStop:   bit_sel = STOP_BIT_SELECT;
      default:  bit_sel = STOP_BIT_SELECT;
    endcase
  end

  // Serializer strobes; the first data bit is presented by the load, so the
  // last bit boundary needs no shift.
  always_comb begin
    ser_load  = (state_q == StIdle) && data_valid;
    par_calc  = (state_q == StIdle) && data_valid;
    ser_shift = (state_q == StData) && baud_tick && (bit_cnt_q != LastBit);
    busy      = (state_q != StIdle);
    tx_done   = tx_done_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-position model checked every cycle, plus
// literal per-scenario expectations on tick sequence and pulse counts.
module tb_uart_tx_ctrl;

  localparam int DW = 8;
  localparam logic [19:0] SeqNoPar = {2'b00, {8{2'b10}}, 2'b01};
  localparam logic [21:0] SeqPar   = {2'b00, {8{2'b10}}, 2'b11, 2'b01};

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       data_valid;
  logic       par_en;
  logic [1:0] bit_sel;
  logic       ser_load;
  logic       ser_shift;
  logic       par_calc;
  logic       busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .data_valid (data_valid),
    .par_en     (par_en),
    .bit_sel    (bit_sel),
    .ser_load   (ser_load),
    .ser_shift  (ser_shift),
    .par_calc   (par_calc),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a frame is a list of bit slots; slot k advances on each tick.
  logic m_busy;
  int   m_k;
  logic m_par;
  logic m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_par  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (data_valid) begin
          m_busy <= 1'b1;
          m_k    <= 0;
          m_par  <= par_en;
        end
      end else if (baud_tick) begin
        if (m_k == DW + 1 + int'(m_par)) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_k <= m_k + 1;
        end
      end
    end
  end

  function automatic logic [1:0] slot_sel(input logic b, input int k, input logic p);
    if (!b)                  return 2'b01;
    if (k == 0)              return 2'b00;
    if (k <= DW)             return 2'b10;
    if (p && k == DW + 1)    return 2'b11;
    return 2'b01;
  endfunction

  // Observation counters and tick-time bit_sel log.
  int          shift_cnt = 0, done_cnt = 0, load_cnt = 0, tick_cnt = 0;
  int          busy_cnt = 0, start_cnt = 0, done_load_cnt = 0;
  logic [31:0] seq_log = '0;

  always @(negedge clk) begin
    check("bit_sel", 32'(bit_sel), 32'(slot_sel(m_busy, m_k, m_par)));
    check("busy", 32'(busy), 32'(m_busy));
    check("tx_done", 32'(tx_done), 32'(m_done));
    check("ser_load", 32'(ser_load), 32'(!m_busy && data_valid));
    check("par_calc", 32'(par_calc), 32'(!m_busy && data_valid));
    check("ser_shift", 32'(ser_shift),
          32'(m_busy && baud_tick && m_k >= 1 && m_k <= DW - 1));
    if (ser_shift) shift_cnt++;
    if (tx_done) done_cnt++;
    if (ser_load) load_cnt++;
    if (busy) busy_cnt++;
    if (busy && bit_sel == 2'b00) start_cnt++;
    if (tx_done && ser_load) done_load_cnt++;
    if (busy && baud_tick) begin
      tick_cnt++;
      seq_log = {seq_log[29:0], bit_sel};
    end
  end

  int tcnt;

  task automatic cyc(input logic dv, input logic pe, input logic tk);
    data_valid = dv;
    par_en     = pe;
    baud_tick  = tk;
    @(posedge clk);
    #1;
    baud_tick  = 1'b0;
  endtask

  // Run n clocks with a tick every 16th clock; optionally toggle par_en.
  task automatic run(input int n, input logic dv, input logic pe, input logic tog);
    for (int i = 0; i < n; i++) begin
      baud_tick  = (tcnt == 15);
      tcnt       = (tcnt + 1) % 16;
      data_valid = dv;
      par_en     = tog ? logic'(i[3]) : pe;
      @(posedge clk);
      #1;
    end
    baud_tick  = 1'b0;
    data_valid = 1'b0;
  endtask

  int b_shift, b_done, b_load, b_tick, b_busy, b_start, b_dl;

  task automatic snap();
    b_shift = shift_cnt; b_done = done_cnt; b_load = load_cnt; b_tick = tick_cnt;
    b_busy = busy_cnt; b_start = start_cnt; b_dl = done_load_cnt;
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; par_en = 1'b0; baud_tick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset bit_sel", 32'(bit_sel), 32'h1);
    check("reset busy", 32'(busy), 32'h0);
    check("reset tx_done", 32'(tx_done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) cyc(0, 0, 0);

    // Frame without parity.
    snap(); tcnt = 0;
    cyc(1, 0, 0);
    run(176, 0, 0, 0);
    check("s1 ticks", 32'(tick_cnt - b_tick), 32'd10);
    check("s1 sequence", 32'(seq_log[19:0]), 32'(SeqNoPar));
    check("s1 shifts", 32'(shift_cnt - b_shift), 32'd7);
    check("s1 tx_done", 32'(done_cnt - b_done), 32'd1);
    check("s1 busy cycles", 32'(busy_cnt - b_busy), 32'd160);

    // Frame with parity; par_en toggles mid-frame.
    snap(); tcnt = 0;
    cyc(1, 1, 0);
    run(184, 0, 1, 1);
    check("s2 ticks", 32'(tick_cnt - b_tick), 32'd11);
    check("s2 sequence", 32'(seq_log[21:0]), 32'(SeqPar));
    check("s2 shifts", 32'(shift_cnt - b_shift), 32'd7);
    check("s2 tx_done", 32'(done_cnt - b_done), 32'd1);

    // Request held through a frame; re-accepted in the tx_done cycle.
    snap(); tcnt = 0;
    cyc(1, 0, 0);
    run(161, 1, 0, 0);
    run(184, 0, 0, 0);
    check("s3 loads", 32'(load_cnt - b_load), 32'd2);
    check("s3 load on done", 32'(done_load_cnt - b_dl), 32'd1);
    check("s3 tx_done", 32'(done_cnt - b_done), 32'd2);
    check("s3 ticks", 32'(tick_cnt - b_tick), 32'd20);
    check("s3 sequence", 32'(seq_log[19:0]), 32'(SeqNoPar));

    // Reset during DATA with bit_cnt=4.
    snap(); tcnt = 0;
    cyc(1, 0, 0);
    run(84, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("s4 rst bit_sel", 32'(bit_sel), 32'h1);
    check("s4 rst busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(40, 0, 0, 0);
    check("s4 no tx_done", 32'(done_cnt - b_done), 32'd0);
    snap(); tcnt = 0;
    cyc(1, 0, 0);
    run(176, 0, 0, 0);
    check("s4 ticks", 32'(tick_cnt - b_tick), 32'd10);
    check("s4 sequence", 32'(seq_log[19:0]), 32'(SeqNoPar));
    check("s4 tx_done", 32'(done_cnt - b_done), 32'd1);

    // Tick in idle, then tick coincident with the request.
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    @(negedge clk);
    check("s5 idle tick busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    snap(); tcnt = 0;
    cyc(1, 0, 1);
    run(176, 0, 0, 0);
    check("s5 start cycles", 32'(start_cnt - b_start), 32'd16);
    check("s5 ticks", 32'(tick_cnt - b_tick), 32'd10);
    check("s5 sequence", 32'(seq_log[19:0]), 32'(SeqNoPar));
    check("s5 tx_done", 32'(done_cnt - b_done), 32'd1);

    repeat (2) cyc(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
